// File: rtl/dma_in_scheduler.sv
// Descriptor FIFO and launch sequencer for the dma_in capture engine.
// Pops one (timer, addr, len) descriptor at a time, drops late ones, arms dma_in and waits for completion.
//
// state | meaning
// IDLE  | waiting for a queued descriptor while dma_in is not busy
// CHECK | head popped onto addr/len lines, deciding if its start time is still ahead
// ARMED | dma_timer_init driven, waiting for dma_done
module dma_in_scheduler #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    srst,
   input  logic [31:0]             ctimer,
   input  logic                    desc_valid,
   output logic                    desc_ready,
   input  logic [31:0]             desc_timer,
   input  logic [31:0]             desc_addr,
   input  logic [31:0]             desc_len,
   input  logic                    flush,
   output logic [31:0]             dma_timer_init,
   output logic [31:0]             dma_start_addr,
   output logic [31:0]             dma_length,
   input  logic                    dma_busy,
   input  logic                    dma_done,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic [CNT_W-1:0]        done_count,
   output logic [CNT_W-1:0]        drop_count,
   output logic                    irq_done,
   output logic                    active
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_ARMED} state_t;

   typedef struct packed {
      logic [31:0] timer;
      logic [31:0] addr;
      logic [31:0] len;
   } desc_t;

   state_t           state_q, state_d;
   desc_t            mem_q [DEPTH];
   desc_t            mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [31:0]      head_timer_q, head_timer_d;
   logic [31:0]      timer_init_q, timer_init_d;
   logic [31:0]      start_addr_q, start_addr_d;
   logic [31:0]      length_q, length_d;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             irq_q, irq_d;
   logic             active_q, active_d;

   logic             push_acc;
   logic             store;
   logic             push_drop;
   logic             pop;
   logic [31:0]      slack;
   logic             late;

   // flush wins over both a simultaneous push and a pop of the head
   assign desc_ready = (count_q < FULL_CNT);
   assign push_acc   = desc_valid && desc_ready && !flush;
   assign store      = push_acc && (desc_timer != 32'd0);
   assign push_drop  = push_acc && (desc_timer == 32'd0);
   assign pop        = (state_q == ST_IDLE) && (count_q != '0) && !dma_busy && !flush;
   assign slack      = head_timer_q - ctimer;
   assign late       = ($signed(slack) <= 32'sd1);

   always_comb begin
      state_d      = state_q;
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q + (PTR_W+1)'(store) - (PTR_W+1)'(pop);
      head_timer_d = head_timer_q;
      timer_init_d = timer_init_q;
      start_addr_d = start_addr_q;
      length_d     = length_q;
      done_cnt_d   = done_cnt_q;
      drop_cnt_d   = drop_cnt_q + CNT_W'(push_drop);
      irq_d        = 1'b0;
      active_d     = active_q;

      if (store) begin
         mem_d[wr_ptr_q] = {desc_timer, desc_addr, desc_len};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               head_timer_d = mem_q[rd_ptr_q].timer;
               start_addr_d = mem_q[rd_ptr_q].addr;
               length_d     = mem_q[rd_ptr_q].len;
               state_d      = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (late) begin
               drop_cnt_d = drop_cnt_d + CNT_W'(1);
               state_d    = ST_IDLE;
            end else begin
               timer_init_d = head_timer_q;
               active_d     = 1'b1;
               state_d      = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (dma_done) begin
               timer_init_d = 32'd0;
               active_d     = 1'b0;
               irq_d        = 1'b1;
               done_cnt_d   = done_cnt_q + CNT_W'(1);
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         head_timer_q <= '0;
         timer_init_q <= '0;
         start_addr_q <= '0;
         length_q     <= '0;
         done_cnt_q   <= '0;
         drop_cnt_q   <= '0;
         irq_q        <= 1'b0;
         active_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         head_timer_q <= head_timer_d;
         timer_init_q <= timer_init_d;
         start_addr_q <= start_addr_d;
         length_q     <= length_d;
         done_cnt_q   <= done_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         irq_q        <= irq_d;
         active_q     <= active_d;
      end
   end

   // storage needs no reset; validity is tracked by the pointers and count
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dma_timer_init = timer_init_q;
   assign dma_start_addr = start_addr_q;
   assign dma_length     = length_q;
   assign fifo_count     = count_q;
   assign done_count     = done_cnt_q;
   assign drop_count     = drop_cnt_q;
   assign irq_done       = irq_q;
   assign active         = active_q;
endmodule

// File: tb/tb_dma_in_scheduler.sv
// Bench for dma_in_scheduler: directed scenarios plus randomized batches checked
// against a queue-based model of descriptor order and counter totals.
module tb_dma_in_scheduler;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic        clk = 1'b0;
   logic        srst;
   logic [31:0] ctimer;
   logic        desc_valid;
   logic        desc_ready;
   logic [31:0] desc_timer;
   logic [31:0] desc_addr;
   logic [31:0] desc_len;
   logic        flush;
   logic [31:0] dma_timer_init;
   logic [31:0] dma_start_addr;
   logic [31:0] dma_length;
   logic        dma_busy;
   logic        dma_done;
   logic [2:0]  fifo_count;
   logic [15:0] done_count;
   logic [15:0] drop_count;
   logic        irq_done;
   logic        active;

   always #5 clk = ~clk;

   dma_in_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .srst(srst), .ctimer(ctimer),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_timer(desc_timer), .desc_addr(desc_addr), .desc_len(desc_len),
      .flush(flush),
      .dma_timer_init(dma_timer_init), .dma_start_addr(dma_start_addr), .dma_length(dma_length),
      .dma_busy(dma_busy), .dma_done(dma_done),
      .fifo_count(fifo_count), .done_count(done_count), .drop_count(drop_count),
      .irq_done(irq_done), .active(active)
   );

   typedef struct {
      logic [31:0] t;
      logic [31:0] a;
      logic [31:0] l;
   } desc_s;

   desc_s q[$];
   int    total = 0;
   int    bad = 0;
   int    exp_done = 0;
   int    exp_drop = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock; inputs change and outputs are sampled 1ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
      ctimer = ctimer + 32'd1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_timer_init"}, dma_timer_init, 32'd0);
      chk({tag, "_addr"}, dma_start_addr, 32'd0);
      chk({tag, "_len"}, dma_length, 32'd0);
      chk({tag, "_fifo"}, 32'(fifo_count), 32'd0);
      chk({tag, "_done"}, 32'(done_count), 32'd0);
      chk({tag, "_drop"}, 32'(drop_count), 32'd0);
      chk({tag, "_irq"}, 32'(irq_done), 32'd0);
      chk({tag, "_active"}, 32'(active), 32'd0);
      chk({tag, "_ready"}, 32'(desc_ready), 32'd1);
   endtask

   task automatic push(input logic [31:0] t, input logic [31:0] a, input logic [31:0] l);
      desc_valid = 1'b1;
      desc_timer = t;
      desc_addr  = a;
      desc_len   = l;
      tick();
      desc_valid = 1'b0;
   endtask

   task automatic wait_armed(input string tag);
      int n = 0;
      while (dma_timer_init == 32'd0 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_arm_timeout"}, 32'(n < 40), 32'd1);
   endtask

   task automatic serve(input string tag, input desc_s d, input int hold);
      wait_armed(tag);
      chk({tag, "_addr"}, dma_start_addr, d.a);
      chk({tag, "_len"}, dma_length, d.l);
      chk({tag, "_timer"}, dma_timer_init, d.t);
      chk({tag, "_active"}, 32'(active), 32'd1);
      repeat (hold) tick();
      chk({tag, "_hold"}, dma_timer_init, d.t);
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      exp_done++;
      chk({tag, "_disarm"}, dma_timer_init, 32'd0);
      chk({tag, "_irq"}, 32'(irq_done), 32'd1);
      chk({tag, "_done_cnt"}, 32'(done_count), 32'(exp_done % 65536));
      tick();
      chk({tag, "_irq_1cyc"}, 32'(irq_done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      desc_s d;
      int    stalls;
      logic [31:0] c;
      srst = 1'b1; ctimer = 32'h1000; desc_valid = 1'b0; desc_timer = '0;
      desc_addr = '0; desc_len = '0; flush = 1'b0; dma_busy = 1'b0; dma_done = 1'b0;
      repeat (3) tick();
      srst = 1'b0;
      tick();
      chk_reset_state("reset");

      // 1: single descriptor, exact pop-to-arm latency
      push(ctimer + 32'd100, 32'h40, 32'd8);
      chk("t1_fifo1", 32'(fifo_count), 32'd1);
      chk("t1_not_armed", dma_timer_init, 32'd0);
      d = '{t: desc_timer, a: 32'h40, l: 32'd8};
      tick();
      chk("t1_check_addr", dma_start_addr, 32'h40);
      chk("t1_check_len", dma_length, 32'd8);
      chk("t1_check_timer0", dma_timer_init, 32'd0);
      chk("t1_fifo0", 32'(fifo_count), 32'd0);
      tick();
      chk("t1_armed", dma_timer_init, d.t);
      serve("t1", d, 3);
      chk("t1_addr_kept", dma_start_addr, 32'h40);

      // 2: fill FIFO while dma_in busy, fifth push stalls, order preserved
      dma_busy = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         d = '{t: ctimer + 32'd1000, a: 32'h100 + 32'(i * 16), l: 32'(i + 1)};
         q.push_back(d);
         push(d.t, d.a, d.l);
      end
      chk("t2_full_cnt", 32'(fifo_count), 32'd4);
      chk("t2_not_ready", 32'(desc_ready), 32'd0);
      d = '{t: ctimer + 32'd1000, a: 32'h200, l: 32'd5};
      q.push_back(d);
      desc_valid = 1'b1; desc_timer = d.t; desc_addr = d.a; desc_len = d.l;
      repeat (3) tick();
      chk("t2_stall_cnt", 32'(fifo_count), 32'd4);
      chk("t2_busy_no_pop", dma_timer_init, 32'd0);
      dma_busy = 1'b0;
      stalls = 0;
      do begin
         tick();
         stalls++;
      end while (!desc_ready && stalls < 20);
      chk("t2_ready_back", 32'(desc_ready), 32'd1);
      tick();
      desc_valid = 1'b0;
      chk("t2_fifth_in", 32'(fifo_count), 32'd4);
      while (q.size() > 0) begin
         d = q.pop_front();
         serve("t2", d, 1);
      end

      // 3: illegal timer, late timer, and the late/not-late boundary
      push(32'd0, 32'h300, 32'd1);
      exp_drop++;
      chk("t3_zero_drop", 32'(drop_count), 32'(exp_drop));
      chk("t3_zero_fifo", 32'(fifo_count), 32'd0);
      c = ctimer;
      push(c - 32'd5, 32'h310, 32'd2);
      tick(); tick();
      exp_drop++;
      chk("t3_late_drop", 32'(drop_count), 32'(exp_drop));
      chk("t3_late_noarm", dma_timer_init, 32'd0);
      chk("t3_late_inactive", 32'(active), 32'd0);
      c = ctimer;
      push(c + 32'd3, 32'h320, 32'd3);
      tick(); tick();
      exp_drop++;
      chk("t3_slack1_drop", 32'(drop_count), 32'(exp_drop));
      chk("t3_slack1_noarm", dma_timer_init, 32'd0);
      c = ctimer;
      push(c + 32'd4, 32'h330, 32'd4);
      tick(); tick();
      chk("t3_slack2_arm", dma_timer_init, c + 32'd4);
      chk("t3_slack2_nodrop", 32'(drop_count), 32'(exp_drop));
      serve("t3", '{t: c + 32'd4, a: 32'h330, l: 32'd4}, 0);

      // 4: start time across the ctimer wrap
      ctimer = 32'hFFFF_FFF0;
      push(32'h10, 32'h400, 32'd16);
      serve("t4", '{t: 32'h10, a: 32'h400, l: 32'd16}, 2);
      chk("t4_nodrop", 32'(drop_count), 32'(exp_drop));

      // 5: flush while armed leaves the in-flight capture alone
      for (int i = 0; i < 4; i++) begin
         d = '{t: ctimer + 32'd800, a: 32'h500 + 32'(i), l: 32'd9};
         if (i == 0) q.push_back(d);
         push(d.t, d.a, d.l);
      end
      chk("t5_queued", 32'(fifo_count), 32'd3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_flushed", 32'(fifo_count), 32'd0);
      chk("t5_still_armed", dma_timer_init, q[0].t);
      chk("t5_still_active", 32'(active), 32'd1);
      d = q.pop_front();
      serve("t5", d, 1);
      repeat (4) tick();
      chk("t5_no_relaunch", dma_timer_init, 32'd0);
      chk("t5_no_drop", 32'(drop_count), 32'(exp_drop));

      // 6: synchronous reset in the middle of a capture
      push(ctimer + 32'd300, 32'h600, 32'd7);
      push(ctimer + 32'd300, 32'h610, 32'd7);
      wait_armed("t6");
      srst = 1'b1;
      tick();
      chk_reset_state("t6_srst");
      srst = 1'b0;
      exp_done = 0; exp_drop = 0;
      q.delete();
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      chk("t6_done_ignored", 32'(done_count), 32'd0);
      chk("t6_irq_ignored", 32'(irq_done), 32'd0);
      repeat (3) tick();
      chk("t6_fifo_cleared", dma_timer_init, 32'd0);

      // randomized batches against the queue model
      for (int b = 0; b < 8; b++) begin
         int k;
         dma_busy = 1'b1;
         k = $urandom_range(1, DEPTH);
         for (int i = 0; i < k; i++) begin
            if ($urandom_range(0, 3) == 0) d.t = 32'd0;
            else d.t = ctimer + 32'd500 + 32'($urandom_range(0, 1000));
            d.a = $urandom;
            d.l = $urandom_range(1, 4096);
            push(d.t, d.a, d.l);
            if (d.t == 32'd0) exp_drop++;
            else q.push_back(d);
         end
         chk("rnd_fifo", 32'(fifo_count), 32'(q.size()));
         chk("rnd_drop", 32'(drop_count), 32'(exp_drop % 65536));
         dma_busy = 1'b0;
         while (q.size() > 0) begin
            d = q.pop_front();
            serve("rnd", d, $urandom_range(0, 5));
         end
      end
      chk("final_done", 32'(done_count), 32'(exp_done % 65536));
      chk("final_drop", 32'(drop_count), 32'(exp_drop % 65536));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
